// File: rtl/uart_pkg.sv
// uart_pkg: state encodings and default timing shared by the UART transmitter and receiver.
// Defining UART_TX_PARITY_EN adds S_PARITY and widens the state encoding to 3 bits.
package uart_pkg;
  localparam int CLKS_PER_BIT_DEF = 5208;
  localparam int HALF_BIT_DEF     = 2604;
  localparam int DATA_BITS        = 8;
`ifdef UART_TX_PARITY_EN
  typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_PARITY, S_STOP} state_e;
`else
  typedef enum logic [1:0] {S_IDLE, S_START, S_DATA, S_STOP} state_e;
`endif
endpackage

// File: rtl/uart_baud_tick.sv
// uart_baud_tick: bit-period counter with a single-cycle tick on the last clock of each bit.
module uart_baud_tick #(
  parameter int CLOCKS_PER_BIT = 5208
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic clr_i,
  output logic tick_o
);
  localparam int W = $clog2(CLOCKS_PER_BIT);
  logic [W-1:0] cnt_q, cnt_d;
  assign tick_o = cnt_q == W'(CLOCKS_PER_BIT - 1);
  assign cnt_d  = (clr_i || tick_o) ? '0 : cnt_q + 1'b1;
  always_ff @(posedge clk_i or negedge rst_ni)
    if (!rst_ni) cnt_q <= '0;
    else         cnt_q <= cnt_d;
endmodule

// File: rtl/uart_tx.sv
// uart_tx: 8N1 UART transmitter, LSB first, one byte per valid/ready handshake.
// Defining UART_TX_PARITY_EN adds a parity bit (PARITY_ODD selects odd parity).
module uart_tx
  import uart_pkg::*;
#(
  parameter int CLOCKS_PER_BIT = CLKS_PER_BIT_DEF,
  parameter int STOP_BITS      = 1
`ifdef UART_TX_PARITY_EN
  , parameter bit PARITY_ODD   = 1'b0
`endif
) (
  input  logic       clk_i,
  input  logic       rst_ni,
  input  logic [7:0] tx_data_i,
  input  logic       tx_valid_i,
  output logic       tx_ready_o,
  output logic       txd_o,
  output logic       tx_busy_o,
  output logic       tx_done_o
);
  state_e     state_q, state_d;
  logic [7:0] shift_q, shift_d;
  logic [2:0] bit_q, bit_d;
  logic       txd_q, txd_d, rdy_q, busy_q, done_q, done_d;
  logic       tick, clr;
`ifdef UART_TX_PARITY_EN
  logic       par_q, par_d;
`endif
  uart_baud_tick #(.CLOCKS_PER_BIT(CLOCKS_PER_BIT)) u_tick (
    .clk_i  (clk_i),
    .rst_ni (rst_ni),
    .clr_i  (clr),
    .tick_o (tick)
  );
  assign clr = state_q == S_IDLE || state_d != state_q;
  // The line level is registered from the current state, so TXD trails the state by one cycle.
  always_comb begin
    state_d = state_q;
    shift_d = shift_q;
    bit_d   = bit_q;
    done_d  = 1'b0;
    txd_d   = 1'b1;
`ifdef UART_TX_PARITY_EN
    par_d   = par_q;
`endif
    case (state_q)
      S_IDLE: if (tx_valid_i) begin
        state_d = S_START;
        shift_d = tx_data_i;
`ifdef UART_TX_PARITY_EN
        par_d   = ^tx_data_i ^ PARITY_ODD;
`endif
      end
      S_START: begin
        txd_d = 1'b0;
        if (tick) state_d = S_DATA;
      end
      S_DATA: begin
        txd_d = shift_q[0];
        if (tick) begin
          shift_d = shift_q >> 1;
          bit_d   = bit_q + 1'b1;
`ifdef UART_TX_PARITY_EN
          if (bit_q == 3'(DATA_BITS - 1)) state_d = S_PARITY;
`else
          if (bit_q == 3'(DATA_BITS - 1)) state_d = S_STOP;
`endif
        end
      end
`ifdef UART_TX_PARITY_EN
      S_PARITY: begin
        txd_d = par_q;
        if (tick) state_d = S_STOP;
      end
`endif
      S_STOP: if (tick) begin
        if (bit_q == 3'(STOP_BITS - 1)) begin
          state_d = S_IDLE;
          bit_d   = '0;
          done_d  = 1'b1;
        end else bit_d = bit_q + 1'b1;
      end
      default: state_d = S_IDLE;
    endcase
  end
  always_ff @(posedge clk_i or negedge rst_ni)
    if (!rst_ni) begin
      state_q <= S_IDLE;
      shift_q <= '0;
      bit_q   <= '0;
      txd_q   <= 1'b1;
      rdy_q   <= 1'b1;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      shift_q <= shift_d;
      bit_q   <= bit_d;
      txd_q   <= txd_d;
      rdy_q   <= state_d == S_IDLE;
      busy_q  <= state_d != S_IDLE;
      done_q  <= done_d;
    end
`ifdef UART_TX_PARITY_EN
  always_ff @(posedge clk_i or negedge rst_ni)
    if (!rst_ni) par_q <= 1'b0;
    else         par_q <= par_d;
`endif
  assign tx_ready_o = rdy_q;
  assign txd_o      = txd_q;
  assign tx_busy_o  = busy_q;
  assign tx_done_o  = done_q;
endmodule

// File: tb/tb_uart_tx.sv
// tb_uart_tx: directed frame checks for uart_tx at 16 clocks per bit.
module tb_uart_tx;
  localparam int CPB = 16;
`ifdef UART_TX_PARITY_EN
  localparam int NB = 11;
`else
  localparam int NB = 10;
`endif
  localparam int FL = NB * CPB;
  logic       clk_i = 1'b0, rst_ni = 1'b1, tx_valid_i = 1'b0;
  logic [7:0] tx_data_i = '0;
  logic       tx_ready_o, txd_o, tx_busy_o, tx_done_o;
  int         checks = 0, errors = 0, cyc = 0;
  int         f1, f2;
  uart_tx #(.CLOCKS_PER_BIT(CPB)) dut (
    .clk_i      (clk_i),
    .rst_ni     (rst_ni),
    .tx_data_i  (tx_data_i),
    .tx_valid_i (tx_valid_i),
    .tx_ready_o (tx_ready_o),
    .txd_o      (txd_o),
    .tx_busy_o  (tx_busy_o),
    .tx_done_o  (tx_done_o)
  );
  always #5 clk_i = ~clk_i;
  always @(posedge clk_i) cyc <= cyc + 1;
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask
  // Line levels in transmit order: bit 0 is the start bit.
  function automatic logic [NB-1:0] frm(input logic [7:0] b);
`ifdef UART_TX_PARITY_EN
    return {1'b1, ^b, b, 1'b0};
`else
    return {1'b1, b, 1'b0};
`endif
  endfunction
  // Called at a negedge; returns at a negedge. inj_at/abort_at are sample indices, -1 disables.
  task automatic send(input logic [7:0] b, input bit hold, input logic [7:0] nxt,
                      input int inj_at, input int abort_at, output int fall);
    logic [NB-1:0] lv, exp_f;
    bit stable;
    int n, rdy_lo, done_n, done_at;
    exp_f = frm(b);
    fall = -1;
    tx_data_i = b;
    tx_valid_i = 1'b1;
    n = 0;
    while (tx_ready_o !== 1'b1 && n < 400) begin
      @(negedge clk_i);
      n++;
    end
    if (tx_ready_o !== 1'b1) begin
      check("ready_timeout", 0, 1);
      tx_valid_i = 1'b0;
      return;
    end
    @(posedge clk_i);
    #1;
    if (hold) tx_data_i = nxt;
    else tx_valid_i = 1'b0;
    @(negedge clk_i);
    check("latency_txd", txd_o, 1);
    check("busy", tx_busy_o, 1);
    rdy_lo = (tx_ready_o === 1'b0) ? 1 : 0;
    lv = '0; stable = 1'b1; done_n = 0; done_at = -1;
    for (int i = 0; i < FL; i++) begin
      @(negedge clk_i);
      if (i == 0) fall = cyc;
      if (i == inj_at) begin
        tx_data_i = 8'hFF;
        tx_valid_i = 1'b1;
      end
      if (i == abort_at) begin
        check("pre_rst_txd", txd_o, exp_f[i/CPB]);
        rst_ni = 1'b0;
        #1;
        check("rst_async_txd", txd_o, 1);
        check("rst_async_busy", tx_busy_o, 0);
        check("rst_async_ready", tx_ready_o, 1);
        @(negedge clk_i);
        rst_ni = 1'b1;
        return;
      end
      if (i % CPB == 0) lv[i/CPB] = txd_o;
      else if (txd_o !== lv[i/CPB]) stable = 1'b0;
      if (tx_ready_o === 1'b0) rdy_lo++;
      if (tx_done_o === 1'b1) begin
        done_n++;
        done_at = i;
      end
    end
    check("frame", lv, exp_f);
    check("bit_stable", stable, 1);
    check("ready_low", rdy_lo, FL);
    check("done_count", done_n, 1);
    check("done_at", done_at, FL - 1);
  endtask
  initial begin
    int dn, bad;
    #2 rst_ni = 1'b0;
    #1;
    check("rst_txd", txd_o, 1);
    check("rst_ready", tx_ready_o, 1);
    check("rst_busy", tx_busy_o, 0);
    check("rst_done", tx_done_o, 0);
    repeat (3) @(negedge clk_i);
    rst_ni = 1'b1;
    dn = 0; bad = 0;
    repeat (100) begin
      @(negedge clk_i);
      if (tx_done_o !== 1'b0) dn++;
      if (txd_o !== 1'b1 || tx_ready_o !== 1'b1 || tx_busy_o !== 1'b0) bad++;
    end
    check("idle_done", dn, 0);
    check("idle_lines", bad, 0);
    send(8'h55, 1'b0, 8'h00, -1, -1, f1);
    send(8'hA5, 1'b1, 8'h3C, -1, -1, f1);
    send(8'h3C, 1'b0, 8'h00, -1, -1, f2);
    check("b2b_period", f2 - f1, FL + 1);
    send(8'h00, 1'b0, 8'h00, 50, -1, f1);
    send(8'hFF, 1'b0, 8'h00, -1, -1, f1);
    send(8'h0F, 1'b0, 8'h00, -1, 88, f1);
    check("post_rst_busy", tx_busy_o, 0);
    check("post_rst_txd", txd_o, 1);
    send(8'h81, 1'b0, 8'h00, -1, -1, f1);
    send(8'h07, 1'b0, 8'h00, -1, -1, f1);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
